// File: rtl/seq_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seq_scan_ctrl
//
// Word-level front end for the serial sequence detector. Parallel words are
// taken over a valid/ready handshake and shifted MSB-first, one bit per clock,
// into a programmable pattern matcher of 1..PAT_W bits. Matches are counted
// (saturating) per scan and scan completion is flagged with a done pulse.
//
// Build option:
//   SEQ_SCAN_OVERLAP_EN  defined   -> overlapping detection (history kept on
//                                     a match)
//                        undefined -> non-overlapping detection (history and
//                                     fill cleared by the matching edge)
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   begin a scan, latches cfg_pattern / cfg_len
//   cfg_pattern  in   PAT_W pattern, LSB-aligned, bit cfg_len-1 first in time
//   cfg_len      in   LEN_W pattern length (0 = never match, >PAT_W clipped)
//   in_valid     in   input word valid
//   in_data      in   DATA_W input word
//   in_last      in   final word of the scan (qualified by in_valid)
//   in_ready     out  block can accept a word (ARMED)
//   busy         out  scan active (not IDLE)
//   match        out  one-cycle pulse per detected pattern
//   match_count  out  CNT_W saturating match count of current/last scan
//   done         out  one-cycle pulse when the scan completes
// ---------------------------------------------------------------------------
module seq_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 8,
  parameter int CNT_W  = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [LEN_W-1:0] PAT_W_L  = LEN_W'(PAT_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Mask selecting the low 'len' bits of a PAT_W vector.
  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < PAT_W; i++) begin
      m[i] = (LEN_W'(i) < len);
    end
    return m;
  endfunction

  // Saturating increment of the match counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (c == CNT_MAX) begin
      r = c;
    end else begin
      r = c + CNT_W'(1);
    end
    return r;
  endfunction

  state_e            state_q,    state_d;
  logic [PAT_W-1:0]  pat_q,      pat_d;
  logic [LEN_W-1:0]  len_q,      len_d;
  logic [DATA_W-1:0] sreg_q,     sreg_d;
  logic              last_q,     last_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  logic [PAT_W-1:0]  hist_q,     hist_d;
  logic [LEN_W-1:0]  fill_q,     fill_d;
  logic              match_q,    match_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

  // Matcher datapath: history/fill as they would be after consuming sreg MSB.
  logic [LEN_W-1:0]  eff_len_s;
  logic [PAT_W-1:0]  hist_nxt_s;
  logic [LEN_W-1:0]  fill_nxt_s;
  logic [PAT_W-1:0]  mask_s;
  logic              hit_s;

  // Matcher evaluation for the bit consumed this cycle.
  always_comb begin
    eff_len_s  = (len_q > PAT_W_L) ? PAT_W_L : len_q;
    hist_nxt_s = {hist_q[PAT_W-2:0], sreg_q[DATA_W-1]};
    if (fill_q == PAT_W_L) begin
      fill_nxt_s = fill_q;
    end else begin
      fill_nxt_s = fill_q + LEN_W'(1);
    end
    mask_s = len_mask(eff_len_s);
    // The new bit takes part in the comparison; zero length never matches.
    hit_s  = (eff_len_s != LEN_W'(0)) &&
             (fill_nxt_s >= eff_len_s) &&
             (((hist_nxt_s ^ pat_q) & mask_s) == '0);
  end

  // Scan FSM next-state and datapath update.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    sreg_d  = sreg_q;
    last_d  = last_q;
    idx_d   = idx_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    count_d = count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d   = cfg_pattern;
          len_d   = cfg_len;
          count_d = '0;
          hist_d  = '0;
          fill_d  = '0;
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ARMED: begin
        // start wins over a word offered in the same cycle.
        if (start) begin
          pat_d   = cfg_pattern;
          len_d   = cfg_len;
          count_d = '0;
          hist_d  = '0;
          fill_d  = '0;
          state_d = ST_ARMED;
        end else if (in_valid) begin
          sreg_d  = in_data;
          last_d  = in_last;
          idx_d   = IDX_LAST;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_ARMED;
        end
      end

      ST_SHIFT: begin
        sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
        hist_d = hist_nxt_s;
        fill_d = fill_nxt_s;
        if (hit_s) begin
          match_d = 1'b1;
          count_d = sat_inc(count_q);
`ifdef SEQ_SCAN_OVERLAP_EN
          hist_d  = hist_nxt_s;
          fill_d  = fill_nxt_s;
`else
          // Restart after a match: the next one needs L fresh bits.
          hist_d  = '0;
          fill_d  = '0;
`endif
        end else begin
          match_d = 1'b0;
        end
        // idx counts the bits still to consume after this one.
        if (idx_q == '0) begin
          state_d = last_q ? ST_DONE : ST_ARMED;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = ST_SHIFT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state.
    in_ready_d = (state_d == ST_ARMED);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      sreg_q     <= '0;
      last_q     <= 1'b0;
      idx_q      <= '0;
      hist_q     <= '0;
      fill_q     <= '0;
      match_q    <= 1'b0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      sreg_q     <= sreg_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      match_q    <= match_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign match       = match_q;
  assign match_count = count_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Testbench for seq_scan_ctrl. Two instances share the stimulus: the default
// build (CNT_W=8) and a CNT_W=2 build for counter saturation. Expected match
// and done events (cycle and counts) come from a bit-queue reference model and
// are queued at word issue; a negedge monitor pops and compares them.
module tb_seq_scan_ctrl;
  localparam int DATA_W = 8;
  localparam int PAT_W  = 8;
  localparam int CNT_W  = 8;
  localparam int LEN_W  = 4;
`ifdef SEQ_SCAN_OVERLAP_EN
  localparam int EXP_OVL = 2;
`else
  localparam int EXP_OVL = 1;
`endif

  typedef struct { int cyc; int cnt; int cnt_s; } ev_t;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, in_last;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [LEN_W-1:0]  cfg_len;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, busy, match, done;
  logic [CNT_W-1:0]  match_count;
  logic              in_ready_s, busy_s, match_s, done_s;
  logic [1:0]        match_count_s;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_fail = 0;
  int  last_acc = 0;
  ev_t mq[$];
  ev_t dq[$];
  bit  bits[$];
  logic [PAT_W-1:0] m_pat;
  int  m_len, m_cnt;

  seq_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .busy(busy), .match(match), .match_count(match_count), .done(done));

  seq_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(2), .LEN_W(LEN_W)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready_s),
    .busy(busy_s), .match(match_s), .match_count(match_count_s), .done(done_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain bit history compared against the pattern.
  task automatic model_word(input logic [DATA_W-1:0] data, input logic last, input int n);
    int L;
    bit hit;
    ev_t e;
    L = (m_len > PAT_W) ? PAT_W : m_len;
    for (int k = 0; k < DATA_W; k++) begin
      bits.push_back(data[DATA_W-1-k]);
      if (bits.size() > PAT_W) void'(bits.pop_front());
      hit = (L > 0) && (bits.size() >= L);
      if (hit) begin
        for (int i = 0; i < L; i++)
          if (bits[bits.size()-L+i] != m_pat[L-1-i]) hit = 0;
      end
      if (hit) begin
        m_cnt++;
        e.cyc = n + 1 + k;
        e.cnt = (m_cnt > 255) ? 255 : m_cnt;
        e.cnt_s = (m_cnt > 3) ? 3 : m_cnt;
        mq.push_back(e);
`ifndef SEQ_SCAN_OVERLAP_EN
        bits.delete();
`endif
      end
    end
    if (last) begin
      e.cyc = n + DATA_W;
      e.cnt = (m_cnt > 255) ? 255 : m_cnt;
      e.cnt_s = (m_cnt > 3) ? 3 : m_cnt;
      dq.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_match"}, match, 0);
    check({tag, "_match_count"}, match_count, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_match_count_sat"}, match_count_s, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'($urandom);
    in_valid = 1'($urandom);
    in_data = DATA_W'($urandom);
    in_last = 1'($urandom);
    cfg_pattern = PAT_W'($urandom);
    cfg_len = LEN_W'($urandom);
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    mq.delete();
    dq.delete();
    bits.delete();
    m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_in_ready", in_ready, 0);
    end
  endtask

  task automatic start_scan(input logic [PAT_W-1:0] pat, input int len);
    start = 1'b1;
    cfg_pattern = pat;
    cfg_len = LEN_W'(len);
    tick();
    start = 1'b0;
    cfg_pattern = PAT_W'($urandom);
    cfg_len = LEN_W'($urandom);
    m_pat = pat;
    m_len = len;
    m_cnt = 0;
    bits.delete();
    check("armed_in_ready", in_ready, 1);
  endtask

  task automatic wait_ready();
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 4 * DATA_W) begin
      tick();
      waited++;
    end
    if (in_ready !== 1'b1) check("in_ready_timeout", in_ready, 1);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] data, input logic last, input bit gap_chk);
    int n;
    wait_ready();
    n = cyc + 1;
    in_valid = 1'b1;
    in_data = data;
    in_last = last;
    if (gap_chk) check("accept_spacing", n - last_acc, DATA_W + 1);
    last_acc = n;
    model_word(data, last, n);
    tick();
    in_valid = 1'b0;
    in_data = DATA_W'($urandom);
    in_last = 1'($urandom);
  endtask

  task automatic finish_scan();
    while (cyc < last_acc + DATA_W) tick();
    check("busy_during_done", busy, 1);
    tick();
    check("busy_after_done", busy, 0);
    check("in_ready_after_done", in_ready, 0);
  endtask

  // Scoreboard monitor: pop expected events when the DUT presents them.
  always @(negedge clk) begin : monitor
    ev_t e;
    bit  exp_m, exp_d;
    while (mq.size() > 0 && mq[0].cyc < cyc) begin
      e = mq.pop_front();
      check("match_missing", 0, e.cyc);
    end
    while (dq.size() > 0 && dq[0].cyc < cyc) begin
      e = dq.pop_front();
      check("done_missing", 0, e.cyc);
    end
    exp_m = (mq.size() > 0) && (mq[0].cyc == cyc);
    if (match || match_s || exp_m) begin
      check("match_pulse", match, exp_m);
      check("match_pulse_sat", match_s, exp_m);
      if (exp_m) begin
        e = mq.pop_front();
        check("match_count", match_count, e.cnt);
        check("match_count_sat", match_count_s, e.cnt_s);
      end
    end
    exp_d = (dq.size() > 0) && (dq[0].cyc == cyc);
    if (done || done_s || exp_d) begin
      check("done_pulse", done, exp_d);
      check("done_pulse_sat", done_s, exp_d);
      if (exp_d) begin
        e = dq.pop_front();
        check("done_count", match_count, e.cnt);
        check("done_count_sat", match_count_s, e.cnt_s);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int c;
    do_reset();

    // Basic 1011 detection in 0x2D: one match after bit index 5.
    start_scan(8'h0B, 4);
    send_word(8'h2D, 1'b1, 1'b0);
    finish_scan();
    check("basic_count", match_count, 1);

    // Overlap behaviour on 0xB6.
    start_scan(8'h0B, 4);
    send_word(8'hB6, 1'b1, 1'b0);
    finish_scan();
    check("overlap_count", match_count, EXP_OVL);

    // Cross-word history and saturation on three back-to-back 0xBB words.
    start_scan(8'h0B, 4);
    send_word(8'hBB, 1'b0, 1'b0);
    send_word(8'hBB, 1'b0, 1'b1);
    send_word(8'hBB, 1'b1, 1'b1);
    finish_scan();
    check("xword_count", match_count, 6);
    check("xword_count_sat", match_count_s, 3);

    // Reset during the 4th SHIFT cycle: no done, everything back to zero.
    start_scan(8'h0B, 4);
    send_word(8'h2D, 1'b1, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    c = cyc;
    tick();
    check_all_zero("mid_reset");
    while (mq.size() > 0 && mq[$].cyc > c) void'(mq.pop_back());
    while (dq.size() > 0 && dq[$].cyc > c) void'(dq.pop_back());
    rst = 1'b0;
    bits.delete();
    m_cnt = 0;
    for (int i = 0; i < DATA_W; i++) begin
      tick();
      check("post_reset_idle", busy, 0);
    end
    start_scan(8'h0B, 4);
    send_word(8'h2D, 1'b1, 1'b0);
    finish_scan();
    check("post_reset_count", match_count, 1);

    // Zero length never matches, done still pulses.
    start_scan(8'hFF, 0);
    send_word(8'hFF, 1'b0, 1'b0);
    send_word(8'h00, 1'b1, 1'b1);
    finish_scan();
    check("len0_count", match_count, 0);

    // start during SHIFT is ignored and does not clear the count.
    start_scan(8'h0B, 4);
    send_word(8'hB0, 1'b0, 1'b0);
    send_word(8'h00, 1'b1, 1'b1);
    start = 1'b1;
    cfg_pattern = 8'h00;
    cfg_len = 4'd1;
    tick();
    start = 1'b0;
    finish_scan();
    check("ignored_start_count", match_count, 1);

    // Randomized scans, including lengths above PAT_W and restarts in ARMED.
    for (int s = 0; s < 30; s++) begin
      int nw, len;
      bit restarted;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 5);
      start_scan(PAT_W'($urandom), len);
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        restarted = 0;
        if (w > 0 && $urandom_range(0, 5) == 0) begin
          wait_ready();
          start_scan(PAT_W'($urandom), $urandom_range(1, 4));
          restarted = 1;
        end
        repeat ($urandom_range(0, 2)) tick();
        send_word(DATA_W'($urandom), (w == nw - 1), (w > 0) && !restarted);
      end
      finish_scan();
    end

    repeat (4) tick();
    check("match_queue_empty", mq.size(), 0);
    check("done_queue_empty", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
